// File: rtl/inst_encoder_if.sv
// Request and encoded-instruction handshakes of the instruction encoder.
// master drives requests and consumes words; slave is the encoder.
interface inst_encoder_if;
  logic        req_vld;
  logic        req_rdy;
  logic [3:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_imm;
  logic        pc_ld;
  logic [31:0] pc_ld_val;
  logic [31:0] enc_pc;
  logic [31:0] enc_inst;
  logic        enc_vld;
  logic        enc_rdy;
  logic        err;

  modport master (
    output req_vld, req_op, req_rd, req_rs1, req_rs2,
    output req_funct3, req_funct7, req_imm,
    output pc_ld, pc_ld_val, enc_rdy,
    input  req_rdy, enc_pc, enc_inst, enc_vld, err
  );

  modport slave (
    input  req_vld, req_op, req_rd, req_rs1, req_rs2,
    input  req_funct3, req_funct7, req_imm,
    input  pc_ld, pc_ld_val, enc_rdy,
    output req_rdy, enc_pc, enc_inst, enc_vld, err
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs field-level requests into RV32IM words, expands LI, and queues
// the words with a running PC behind a valid/ready output.
module inst_encoder #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  inst_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_IA   = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_BR   = 4'd4;
  localparam logic [3:0] OP_JAL  = 4'd5;
  localparam logic [3:0] OP_JALR = 4'd6;
  localparam logic [3:0] OP_LUI  = 4'd7;
  localparam logic [3:0] OP_AUI  = 4'd8;
  localparam logic [3:0] OP_LI   = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd10;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign imm = bus.req_imm;
  assign rd  = bus.req_rd;
  assign rs1 = bus.req_rs1;
  assign rs2 = bus.req_rs2;
  assign f3  = bus.req_funct3;
  assign f7  = bus.req_funct7;

  logic        fit12;
  logic        fit13;
  logic        fit21;
  logic [11:0] ia_imm;
  logic [19:0] li_hi;

  assign fit12 = imm[31:11] == {21{imm[11]}};
  assign fit13 = imm[31:12] == {20{imm[12]}};
  assign fit21 = imm[31:20] == {12{imm[20]}};
  // Shift-immediate forms carry funct7 in the upper imm bits.
  assign ia_imm = (f3 == 3'b001 || f3 == 3'b101) ?
                  {f7, imm[4:0]} : imm[11:0];
  // Rounds so the sign-extended low part cancels back out.
  assign li_hi = imm[31:12] + 20'(imm[11]);

  logic [31:0] w0;
  logic [31:0] w1;
  logic        legal;
  logic        two;

  always_comb begin
    w0    = NOP_W;
    w1    = NOP_W;
    legal = 1'b1;
    two   = 1'b0;
    unique case (1'b1)
      bus.req_op == OP_R:
        w0 = {f7, rs2, rs1, f3, rd, 7'b0110011};
      bus.req_op == OP_IA: begin
        legal = fit12;
        w0 = {ia_imm, rs1, f3, rd, 7'b0010011};
      end
      bus.req_op == OP_LD: begin
        legal = fit12;
        w0 = {imm[11:0], rs1, f3, rd, 7'b0000011};
      end
      bus.req_op == OP_ST: begin
        legal = fit12;
        w0 = {imm[11:5], rs2, rs1, f3,
              imm[4:0], 7'b0100011};
      end
      bus.req_op == OP_BR: begin
        legal = fit13 && !imm[0];
        w0 = {imm[12], imm[10:5], rs2, rs1, f3,
              imm[4:1], imm[11], 7'b1100011};
      end
      bus.req_op == OP_JAL: begin
        legal = fit21 && !imm[0];
        w0 = {imm[20], imm[10:1], imm[11],
              imm[19:12], rd, 7'b1101111};
      end
      bus.req_op == OP_JALR: begin
        legal = fit12;
        w0 = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      end
      bus.req_op == OP_LUI:
        w0 = {imm[31:12], rd, 7'b0110111};
      bus.req_op == OP_AUI:
        w0 = {imm[31:12], rd, 7'b0010111};
      bus.req_op == OP_LI: begin
        if (fit12) begin
          w0 = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
        end else begin
          w0  = {li_hi, rd, 7'b0110111};
          two = imm[11:0] != 12'd0;
        end
        w1 = {imm[11:0], rd, 3'b000, rd, 7'b0010011};
      end
      bus.req_op == OP_NOP:
        w0 = NOP_W;
      default:
        legal = 1'b0;
    endcase
  end

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic [31:0]   pc;
  logic [31:0]   li_word;
  logic          err_q;

  logic        full;
  logic        vld;
  logic        acc;
  logic        push;
  logic        pop;
  logic [31:0] push_word;

  assign full = count == CW'(DEPTH);
  assign vld  = count != '0;

  assign bus.req_rdy  = state == IDLE && !full && !bus.pc_ld;
  assign bus.enc_vld  = vld;
  assign bus.enc_pc   = head[63:32];
  assign bus.enc_inst = head[31:0];
  assign bus.err      = err_q;

  assign acc = bus.req_vld && bus.req_rdy;
  assign pop = vld && bus.enc_rdy && !bus.pc_ld;
  assign push_word = (state == LI_LO) ? li_word : w0;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        push = acc && legal;
        if (acc && legal && two) state_nxt = LI_LO;
      end
      LI_LO: begin
        push = !full;
        if (!full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.pc_ld) begin
      push      = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head    <= '0;
      pc      <= RESET_PC;
      li_word <= NOP_W;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= acc && !legal;
      if (state == IDLE && acc) li_word <= w1;
      if (bus.pc_ld) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        pc     <= bus.pc_ld_val;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          pc     <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop) count <= count + CW'(1);
        if (!push && pop) count <= count - CW'(1);
        // Head register mirrors the slot at rd_ptr after the update.
        if (push && (count == '0 || (count == CW'(1) && pop)))
          head <= {pc, push_word};
        else if (pop && count > CW'(1))
          head <= mem[rd_ptr + AW'(1)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pc, push_word};
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus a
// randomized run against a field-level encoding model.
module tb_inst_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_encoder_if bus ();

  inst_encoder #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void model(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [31:0] imm,
    output int          n,
    output logic [31:0] w0,
    output logic [31:0] w1
  );
    int s;
    int lo;
    logic [31:0] regs;
    logic [31:0] fld;
    logic [31:0] up;
    s = imm;
    n = 1;
    w0 = 0;
    w1 = 0;
    regs = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
    case (op)
      0: w0 = (32'(f7) << 25) | (32'(rs2) << 20) | regs | 'h33;
      1, 2, 6: begin
        if (s < -2048 || s > 2047) n = 0;
        fld = imm & 'hfff;
        if (op == 1 && (f3 == 1 || f3 == 5))
          fld = (32'(f7) << 5) | (imm & 31);
        if (op == 1) w0 = (fld << 20) | regs | 'h13;
        if (op == 2) w0 = (fld << 20) | regs | 'h03;
        if (op == 6)
          w0 = (fld << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 'h67;
      end
      3: begin
        if (s < -2048 || s > 2047) n = 0;
        w0 = (((imm >> 5) & 'h7f) << 25) | (32'(rs2) << 20)
           | (32'(rs1) << 15) | (32'(f3) << 12)
           | ((imm & 31) << 7) | 'h23;
      end
      4: begin
        if (s < -4096 || s > 4095 || imm[0]) n = 0;
        w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3f) << 25)
           | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
           | (((imm >> 1) & 'hf) << 8) | (((imm >> 11) & 1) << 7)
           | 'h63;
      end
      5: begin
        if (s < -(1 << 20) || s > (1 << 20) - 1 || imm[0]) n = 0;
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3ff) << 21)
           | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hff) << 12)
           | (32'(rd) << 7) | 'h6f;
      end
      7: w0 = (imm & 'hfffff000) | (32'(rd) << 7) | 'h37;
      8: w0 = (imm & 'hfffff000) | (32'(rd) << 7) | 'h17;
      9: begin
        if (s >= -2048 && s <= 2047) begin
          w0 = ((imm & 'hfff) << 20) | (32'(rd) << 7) | 'h13;
        end else begin
          lo = ((s & 'hfff) ^ 'h800) - 'h800;
          up = imm - 32'(lo);
          w0 = (up & 'hfffff000) | (32'(rd) << 7) | 'h37;
          if (lo != 0) begin
            n = 2;
            w1 = ((32'(lo) & 'hfff) << 20) | (32'(rd) << 15)
               | (32'(rd) << 7) | 'h13;
          end
        end
      end
      10: w0 = 'h13;
      default: n = 0;
    endcase
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    bus.req_vld = 0;
    bus.pc_ld = 0;
    bus.pc_ld_val = 0;
    bus.enc_rdy = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_req(input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
    bit ok = 0;
    bus.req_op = op;
    bus.req_rd = rd;
    bus.req_rs1 = rs1;
    bus.req_rs2 = rs2;
    bus.req_funct3 = f3;
    bus.req_funct7 = f7;
    bus.req_imm = imm;
    bus.req_vld = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout req_rdy stayed %b want 1", bus.req_rdy);
    end
    @(posedge clk); #1;
    bus.req_vld = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++;
    if (bus.enc_vld !== 1'b0) begin
      errors++; $display("FAIL rst_vld got %b want 0", bus.enc_vld);
    end
    checks++;
    if (bus.enc_pc !== 32'h0) begin
      errors++; $display("FAIL rst_pc got %h want 0", bus.enc_pc);
    end
    checks++;
    if (bus.enc_inst !== 32'h0) begin
      errors++; $display("FAIL rst_inst got %h want 0", bus.enc_inst);
    end
    checks++;
    if (bus.req_rdy !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL rst_rdy_err got %b%b want 10", bus.req_rdy, bus.err);
    end
  endtask

  task automatic test_addi();
    reset_dut();
    do_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(negedge clk);
    checks++;
    if ({bus.enc_vld, bus.enc_pc, bus.enc_inst}
        !== {1'b1, 32'h0, 32'h00500093}) begin
      errors++;
      $display("FAIL addi got %b %h %h want 1 0 00500093",
               bus.enc_vld, bus.enc_pc, bus.enc_inst);
    end
  endtask

  task automatic test_li();
    logic [31:0] exp_w [3];
    int k = 0;
    reset_dut();
    do_req(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
    @(negedge clk);
    checks++;
    if ({bus.enc_pc, bus.enc_inst, bus.req_rdy}
        !== {32'h0, 32'h123452B7, 1'b0}) begin
      errors++;
      $display("FAIL li_lui got %h %h rdy %b want 0 123452b7 rdy 0",
               bus.enc_pc, bus.enc_inst, bus.req_rdy);
    end
    @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b1) begin
      errors++; $display("FAIL li_rdy got %b want 1", bus.req_rdy);
    end
    bus.enc_rdy = 1;
    @(posedge clk); #1;
    bus.enc_rdy = 0;
    @(negedge clk);
    checks++;
    if ({bus.enc_vld, bus.enc_pc, bus.enc_inst}
        !== {1'b1, 32'h4, 32'h67828293}) begin
      errors++;
      $display("FAIL li_addi got %b %h %h want 1 4 67828293",
               bus.enc_vld, bus.enc_pc, bus.enc_inst);
    end
    reset_dut();
    exp_w[0] = 32'h000010B7;
    exp_w[1] = 32'h80008093;
    exp_w[2] = 32'h00010137;
    do_req(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    do_req(4'd9, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h10000);
    bus.enc_rdy = 1;
    for (int i = 0; i < 20 && k < 3; i++) begin
      @(negedge clk);
      if (bus.enc_vld) begin
        checks++;
        if (bus.enc_inst !== exp_w[k] || bus.enc_pc !== 32'(k * 4)) begin
          errors++;
          $display("FAIL li_seq%0d got %h@%h want %h@%h", k,
                   bus.enc_inst, bus.enc_pc, exp_w[k], k * 4);
        end
        k++;
      end
    end
    bus.enc_rdy = 0;
    checks++;
    if (k != 3) begin
      errors++; $display("FAIL li_seq_count got %0d want 3", k);
    end
  endtask

  task automatic test_r_branch();
    reset_dut();
    do_req(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.enc_inst !== 32'h002081B3 || bus.enc_pc !== 32'h0) begin
      errors++;
      $display("FAIL add got %h@%h want 002081b3@0",
               bus.enc_inst, bus.enc_pc);
    end
    bus.enc_rdy = 1;
    @(posedge clk); #1;
    bus.enc_rdy = 0;
    do_req(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || bus.enc_vld !== 1'b0) begin
      errors++;
      $display("FAIL beq_drop err %b vld %b want 1 0",
               bus.err, bus.enc_vld);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL err_pulse got %b want 0", bus.err);
    end
    do_req(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.enc_pc !== 32'h4 || bus.enc_inst !== 32'h13) begin
      errors++;
      $display("FAIL pc_after_drop got %h@%h want 00000013@4",
               bus.enc_inst, bus.enc_pc);
    end
  endtask

  task automatic test_full();
    int k = 0;
    reset_dut();
    for (int i = 0; i < 4; i++)
      do_req(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b0 || bus.enc_pc !== 32'h0) begin
      errors++;
      $display("FAIL full rdy %b pc %h want 0 0", bus.req_rdy, bus.enc_pc);
    end
    bus.enc_rdy = 1;
    bus.req_vld = 1;
    @(posedge clk); #1;
    bus.enc_rdy = 0;
    @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b1 || bus.enc_pc !== 32'h4) begin
      errors++;
      $display("FAIL full_pop rdy %b pc %h want 1 4",
               bus.req_rdy, bus.enc_pc);
    end
    @(posedge clk); #1;
    bus.req_vld = 0;
    bus.enc_rdy = 1;
    for (int i = 0; i < 20 && k < 4; i++) begin
      @(negedge clk);
      if (bus.enc_vld) begin
        checks++;
        if (bus.enc_pc !== 32'(4 + k * 4)) begin
          errors++;
          $display("FAIL full_drain%0d got %h want %h", k,
                   bus.enc_pc, 4 + k * 4);
        end
        k++;
      end
    end
    bus.enc_rdy = 0;
    checks++;
    if (k != 4) begin
      errors++; $display("FAIL full_drain_count got %0d want 4", k);
    end
  endtask

  task automatic test_pc_ld();
    bit seen = 0;
    reset_dut();
    do_req(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    do_req(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    do_req(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
    bus.pc_ld = 1;
    bus.pc_ld_val = 32'h100;
    @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b0) begin
      errors++; $display("FAIL pcld_rdy got %b want 0", bus.req_rdy);
    end
    @(posedge clk); #1;
    bus.pc_ld = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.enc_vld) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL pcld_flush vld seen 1 want 0");
    end
    do_req(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({bus.enc_vld, bus.enc_pc} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL pcld_pc got %b %h want 1 00000100",
               bus.enc_vld, bus.enc_pc);
    end
    reset_dut();
    do_req(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.enc_vld) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rst_mid_li vld seen 1 want 0");
    end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [31:0] mpc = 0;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] e;
    bit exp_err = 0;
    int n;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (bus.err !== exp_err) begin
        errors++;
        $display("FAIL rnd_err c%0d got %b want %b", c, bus.err, exp_err);
      end
      if (bus.enc_vld && bus.enc_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra got %h@%h want none",
                   bus.enc_inst, bus.enc_pc);
        end else begin
          e = q.pop_front();
          if ({bus.enc_pc, bus.enc_inst} !== e) begin
            errors++;
            $display("FAIL rnd_word got %h@%h want %h@%h",
                     bus.enc_inst, bus.enc_pc, e[31:0], e[63:32]);
          end
        end
      end
      exp_err = 0;
      if (bus.req_vld && bus.req_rdy) begin
        model(bus.req_op, bus.req_rd, bus.req_rs1, bus.req_rs2,
              bus.req_funct3, bus.req_funct7, bus.req_imm, n, w0, w1);
        if (n == 0) exp_err = 1;
        if (n >= 1) begin q.push_back({mpc, w0}); mpc += 4; end
        if (n == 2) begin q.push_back({mpc, w1}); mpc += 4; end
      end
      @(posedge clk); #1;
      bus.req_vld = c < 2900 && $urandom_range(0, 2) != 0;
      bus.enc_rdy = $urandom_range(0, 3) != 0;
      bus.req_op = ($urandom_range(0, 9) == 0) ?
                   4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      bus.req_rd = 5'($urandom);
      bus.req_rs1 = 5'($urandom);
      bus.req_rs2 = 5'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: bus.req_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: bus.req_imm = $urandom;
        2: bus.req_imm = 32'($urandom_range(0, 1 << 22)) - 32'h200000;
        default: bus.req_imm = 32'($urandom_range(0, 3)) + 32'h7fe;
      endcase
    end
    bus.req_vld = 0;
    bus.enc_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.enc_vld && q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.enc_pc, bus.enc_inst} !== e) begin
          errors++;
          $display("FAIL rnd_drain got %h@%h want %h@%h",
                   bus.enc_inst, bus.enc_pc, e[31:0], e[63:32]);
        end
      end
    end
    bus.enc_rdy = 0;
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rnd_left got %0d want 0", q.size());
    end
  endtask

  initial begin
    bus.req_vld = 0;
    bus.req_op = 0;
    bus.req_rd = 0;
    bus.req_rs1 = 0;
    bus.req_rs2 = 0;
    bus.req_funct3 = 0;
    bus.req_funct7 = 0;
    bus.req_imm = 0;
    bus.pc_ld = 0;
    bus.pc_ld_val = 0;
    bus.enc_rdy = 0;
    test_reset();
    test_addi();
    test_li();
    test_r_branch();
    test_full();
    test_pc_ld();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
